// File: rtl/dose_pkg.sv
// Shared types for the dose scheduler: FSM states, schedule table entry and
// the missed-dose counter ceiling.
package dose_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic       en;
        logic [4:0] hour;
        logic [5:0] min;
    } sched_entry_t;

    localparam logic [7:0] MISSED_MAX = 8'd255;

endpackage

// File: rtl/dose_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// rr_ptr+1 with wrap-around, so the last granted channel gets lowest priority.
module rr_arbiter #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    always_comb begin
        int          idx_i;
        logic [IW-1:0] idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx_i     = 0;
        idx       = '0;
        for (int i = 1; i <= N_CH; i++) begin
            idx_i = int'(rr_ptr) + i;
            if (idx_i >= N_CH) idx_i = idx_i - N_CH;
            idx = IW'(idx_i);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/dose_scheduler.sv
// Multi-compartment dispenser: schedule table matched against the RTC, a
// pending-request queue, one-motor-at-a-time pulse/gap FSM and an ack timer.
module dose_scheduler
    import dose_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int N_SLOT        = 3,
    parameter int PULSE_CYCLES  = 50000000,
    parameter int GAP_CYCLES    = 5000000,
    parameter int ACK_TIMEOUT_S = 900
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            sec_tick,
    input  logic [5:0]      seconds,
    input  logic [5:0]      minutes,
    input  logic [4:0]      hours,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_ch,
    input  logic [2:0]      cfg_slot,
    input  logic            cfg_en,
    input  logic [4:0]      cfg_hour,
    input  logic [5:0]      cfg_min,
    input  logic [N_CH-1:0] override,
    input  logic            ack,
    output logic [N_CH-1:0] motor,
    output logic            busy,
    output logic [N_CH-1:0] pending,
    output logic            alarm,
    output logic [7:0]      missed_cnt,
    output logic [1:0]      state_dbg
);

    localparam int IW = $clog2(N_CH);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CW = (PW > GW) ? PW : GW;
    localparam int AW = $clog2(ACK_TIMEOUT_S + 1);

    sched_entry_t    tbl_q [N_CH][N_SLOT];
    sched_entry_t    tbl_d [N_CH][N_SLOT];
    logic [N_CH-1:0] ovr_prev_q, pending_q, pending_d, sched_q, sched_d;
    logic [N_CH-1:0] motor_q, motor_d, match, ovr_rise;
    state_t          state_q, state_d;
    logic [IW-1:0]   rr_q, rr_d, gnt_idx;
    logic            gnt_valid, gsched_q, gsched_d, pulse_done, miss;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            armed_q, armed_d, alarm_q, alarm_d;
    logic [AW-1:0]   tcnt_q, tcnt_d;
    logic [7:0]      missed_q, missed_d;

    rr_arbiter #(.N_CH(N_CH), .IW(IW)) u_arb (
        .req      (pending_q),
        .rr_ptr   (rr_q),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid)
    );

    // Several matching slots of one channel collapse into a single request.
    always_comb begin
        match = '0;
        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (sec_tick && seconds == 6'd0 && tbl_q[c][s].en &&
                    tbl_q[c][s].hour == hours && tbl_q[c][s].min == minutes)
                    match[c] = 1'b1;
            end
        end
    end

    assign ovr_rise = override & ~ovr_prev_q;

    always_comb begin
        tbl_d      = tbl_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        gsched_d   = gsched_q;
        motor_d    = motor_q;
        pending_d  = pending_q;
        sched_d    = sched_q;
        pulse_done = 1'b0;
        miss       = 1'b0;
        armed_d    = armed_q;
        tcnt_d     = tcnt_q;
        alarm_d    = alarm_q;
        missed_d   = missed_q;

        for (int c = 0; c < N_CH; c++) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if (cfg_we && int'(cfg_ch) == c && int'(cfg_slot) == s)
                    tbl_d[c][s] = {cfg_en, cfg_hour, cfg_min};
            end
        end

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    pending_d[gnt_idx] = 1'b0;
                    rr_d               = gnt_idx;
                    gsched_d           = sched_q[gnt_idx];
                    cnt_d              = '0;
                    motor_d            = '0;
                    motor_d[gnt_idx]   = 1'b1;
                    state_d            = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                    pulse_done = 1'b1;
                    motor_d    = '0;
                    cnt_d      = '0;
                    state_d    = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                               cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase

        // New requests are applied after the grant clear so a same-cycle set wins.
        pending_d = pending_d | match | ovr_rise;
        for (int c = 0; c < N_CH; c++) begin
            if (ovr_rise[c]) sched_d[c] = 1'b0;
            if (match[c])    sched_d[c] = 1'b1;
        end

        if (armed_q) begin
            if (ack) begin
                armed_d = 1'b0;
            end else if (sec_tick && (tcnt_q + AW'(1)) == AW'(ACK_TIMEOUT_S)) begin
                miss    = 1'b1;
                armed_d = 1'b0;
            end else if (sec_tick) begin
                tcnt_d = tcnt_q + AW'(1);
            end
        end
        // A fresh scheduled dose while still waiting writes off the older one.
        if (pulse_done && gsched_q) begin
            if (armed_q && !ack) miss = 1'b1;
            armed_d = 1'b1;
            tcnt_d  = '0;
        end

        if (ack)       alarm_d = 1'b0;
        else if (miss) alarm_d = 1'b1;
        if (miss && missed_q != MISSED_MAX) missed_d = missed_q + 8'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < N_CH; c++)
                for (int s = 0; s < N_SLOT; s++)
                    tbl_q[c][s] <= '0;
            ovr_prev_q <= '0;
            pending_q  <= '0;
            sched_q    <= '0;
            motor_q    <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_q       <= '0;
            gsched_q   <= 1'b0;
            armed_q    <= 1'b0;
            tcnt_q     <= '0;
            alarm_q    <= 1'b0;
            missed_q   <= '0;
        end else begin
            tbl_q      <= tbl_d;
            ovr_prev_q <= override;
            pending_q  <= pending_d;
            sched_q    <= sched_d;
            motor_q    <= motor_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            gsched_q   <= gsched_d;
            armed_q    <= armed_d;
            tcnt_q     <= tcnt_d;
            alarm_q    <= alarm_d;
            missed_q   <= missed_d;
        end
    end

    assign motor      = motor_q;
    assign busy       = (state_q != IDLE);
    assign pending    = pending_q;
    assign alarm      = alarm_q;
    assign missed_cnt = missed_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dose_scheduler.sv
// Directed bench for dose_scheduler with small pulse/gap/timeout parameters;
// a cycle table for the basic dose plus hand-written multi-cycle sequences.
module tb_dose_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       sec_tick = 1'b0;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [4:0] hours = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [2:0] cfg_slot = '0;
    logic       cfg_en = 1'b0;
    logic [4:0] cfg_hour = '0;
    logic [5:0] cfg_min = '0;
    logic [3:0] override = '0;
    logic       ack = 1'b0;
    logic [3:0] motor;
    logic       busy;
    logic [3:0] pending;
    logic       alarm;
    logic [7:0] missed_cnt;
    logic [1:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    dose_scheduler #(
        .N_CH(4), .N_SLOT(3), .PULSE_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT_S(3)
    ) dut (
        .clock(clock), .resetn(resetn), .sec_tick(sec_tick), .seconds(seconds),
        .minutes(minutes), .hours(hours), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_slot(cfg_slot), .cfg_en(cfg_en), .cfg_hour(cfg_hour), .cfg_min(cfg_min),
        .override(override), .ack(ack), .motor(motor), .busy(busy),
        .pending(pending), .alarm(alarm), .missed_cnt(missed_cnt), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    typedef struct {
        logic       tick;
        logic [5:0] sec;
        logic [3:0] exp_motor;
        logic       exp_busy;
        logic [3:0] exp_pend;
        logic       exp_alarm;
        logic [7:0] exp_missed;
    } vec_t;

    vec_t vecs [14];
    logic [3:0] exp_q [$];

    function automatic vec_t mk(input logic t, input logic [5:0] s, input logic [3:0] m,
                                input logic b, input logic [3:0] p, input logic a,
                                input logic [7:0] c);
        vec_t v;
        v.tick = t; v.sec = s; v.exp_motor = m; v.exp_busy = b;
        v.exp_pend = p; v.exp_alarm = a; v.exp_missed = c;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [2:0] slot, input logic en,
                             input logic [4:0] hr, input logic [5:0] mn);
        cfg_ch = ch; cfg_slot = slot; cfg_en = en; cfg_hour = hr; cfg_min = mn;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic tick(input logic [5:0] sec);
        sec_tick = 1'b1;
        seconds = sec;
        step();
        sec_tick = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        int on_cnt;
        int rise_cnt;
        logic [3:0] prev_m;

        vecs[0]  = mk(1, 0, 4'b0000, 0, 4'b0010, 0, 0);
        vecs[1]  = mk(0, 0, 4'b0010, 1, 4'b0000, 0, 0);
        vecs[2]  = mk(0, 0, 4'b0010, 1, 4'b0000, 0, 0);
        vecs[3]  = mk(0, 0, 4'b0010, 1, 4'b0000, 0, 0);
        vecs[4]  = mk(0, 0, 4'b0010, 1, 4'b0000, 0, 0);
        vecs[5]  = mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        vecs[6]  = mk(0, 0, 4'b0000, 1, 4'b0000, 0, 0);
        vecs[7]  = mk(0, 0, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[8]  = mk(1, 1, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[9]  = mk(0, 1, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[10] = mk(1, 1, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[11] = mk(0, 1, 4'b0000, 0, 4'b0000, 0, 0);
        vecs[12] = mk(1, 1, 4'b0000, 0, 4'b0000, 1, 1);
        vecs[13] = mk(0, 1, 4'b0000, 0, 4'b0000, 1, 1);

        do_reset();
        chk("rst_motor", motor, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_missed", missed_cnt, 0);

        // Single scheduled dose at 08:00, then a timeout with no ack.
        cfg_write(1, 0, 1, 8, 0);
        hours = 8; minutes = 0;
        for (int i = 0; i < 14; i++) begin
            sec_tick = vecs[i].tick;
            seconds = vecs[i].sec;
            step();
            chk($sformatf("t1_motor[%0d]", i), motor, vecs[i].exp_motor);
            chk($sformatf("t1_busy[%0d]", i), busy, vecs[i].exp_busy);
            chk($sformatf("t1_pend[%0d]", i), pending, vecs[i].exp_pend);
            chk($sformatf("t1_alarm[%0d]", i), alarm, vecs[i].exp_alarm);
            chk($sformatf("t1_missed[%0d]", i), missed_cnt, vecs[i].exp_missed);
        end
        sec_tick = 1'b0;

        // Three channels in the same minute, rr=1 so ch2 goes first.
        cfg_write(0, 1, 1, 8, 5);
        cfg_write(2, 2, 1, 8, 5);
        cfg_write(3, 0, 1, 8, 5);
        hours = 8; minutes = 5;
        tick(0);
        chk("t2_pending", pending, 4'b1101);
        repeat (4) exp_q.push_back(4'b0100);
        repeat (3) exp_q.push_back(4'b0000);
        repeat (4) exp_q.push_back(4'b1000);
        repeat (3) exp_q.push_back(4'b0000);
        repeat (4) exp_q.push_back(4'b0001);
        repeat (3) exp_q.push_back(4'b0000);
        while (exp_q.size() > 0) begin
            step();
            chk("t2_motor", motor, exp_q.pop_front());
            chk("t2_onehot", ($countones(motor) <= 1), 1);
        end
        chk("t2_busy", busy, 0);
        chk("t2_missed", missed_cnt, 3);
        chk("t2_alarm", alarm, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("t2_ack_alarm", alarm, 0);
        chk("t2_ack_missed", missed_cnt, 3);

        // Held override gives exactly one unscheduled pulse.
        do_reset();
        on_cnt = 0; rise_cnt = 0; prev_m = '0;
        override = 4'b1000;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) override = 4'b0000;
            step();
            if (motor == 4'b1000) on_cnt++;
            if (motor != 4'b0000 && prev_m == 4'b0000) rise_cnt++;
            prev_m = motor;
        end
        chk("t3_on_cycles", on_cnt, 4);
        chk("t3_pulses", rise_cnt, 1);
        repeat (4) begin
            tick(1);
            step();
        end
        chk("t3_alarm", alarm, 0);
        chk("t3_missed", missed_cnt, 0);
        chk("t3_pending", pending, 0);

        // Ack after two ticks, then ack coinciding with the timeout tick.
        do_reset();
        cfg_write(1, 0, 1, 8, 0);
        hours = 8; minutes = 0;
        tick(0);
        repeat (8) step();
        chk("t4_busy", busy, 0);
        tick(1); step();
        tick(1); step();
        ack = 1'b1; step(); ack = 1'b0;
        repeat (3) begin tick(1); step(); end
        chk("t4_ack_alarm", alarm, 0);
        chk("t4_ack_missed", missed_cnt, 0);
        tick(0);
        repeat (8) step();
        tick(1); step();
        tick(1); step();
        sec_tick = 1'b1; seconds = 1; ack = 1'b1;
        step();
        sec_tick = 1'b0; ack = 1'b0;
        chk("t4_tie_alarm", alarm, 0);
        chk("t4_tie_missed", missed_cnt, 0);
        repeat (3) begin tick(1); step(); end
        chk("t4_post_missed", missed_cnt, 0);

        // Reset during the second pulse cycle.
        do_reset();
        cfg_write(1, 0, 1, 8, 0);
        hours = 8; minutes = 0;
        tick(0);
        step();
        step();
        chk("t5_motor_pre", motor, 4'b0010);
        resetn = 1'b0;
        #1;
        chk("t5_motor_async", motor, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pending", pending, 0);
        chk("t5_alarm", alarm, 0);
        chk("t5_missed", missed_cnt, 0);
        step();
        resetn = 1'b1;
        step();
        tick(0);
        chk("t5_rematch_pending", pending, 0);
        on_cnt = 0;
        repeat (10) begin
            step();
            if (motor != 4'b0000) on_cnt++;
        end
        chk("t5_no_dispense", on_cnt, 0);

        // Saturation of the missed counter and out-of-range config writes.
        do_reset();
        cfg_write(1, 0, 1, 8, 0);
        hours = 8; minutes = 0;
        for (int k = 0; k < 256; k++) begin
            tick(0);
            repeat (8) step();
            repeat (3) begin tick(1); step(); end
        end
        chk("t6_missed_sat", missed_cnt, 255);
        chk("t6_alarm", alarm, 1);
        cfg_write(5, 0, 1, 9, 0);
        cfg_write(1, 4, 0, 0, 0);
        hours = 9; minutes = 0;
        tick(0);
        chk("t6_bad_ch_pending", pending, 0);
        repeat (3) step();
        chk("t6_bad_ch_busy", busy, 0);
        hours = 8; minutes = 0;
        tick(0);
        chk("t6_table_kept", pending, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
